// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control from decode/execute, ROM data in, and IF/ID plus statistics out.
// The master modport is the fetch stage. The slave modport is its environment.
interface instruction_fetch_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] instruction;
    logic [WIDTH-1:0] pc_address;
    logic [WIDTH-1:0] if_id_pc;
    logic [WIDTH-1:0] if_id_instr;
    logic             if_id_valid;
    logic [31:0]      fetch_count;
    logic [31:0]      stall_count;

    modport master (
        input  stall, branch_taken, branch_target, instruction,
        output pc_address, if_id_pc, if_id_instr, if_id_valid, fetch_count, stall_count
    );

    modport slave (
        output stall, branch_taken, branch_target, instruction,
        input  pc_address, if_id_pc, if_id_instr, if_id_valid, fetch_count, stall_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, feeds the combinational ROM, and fills IF/ID.
// It handles stalls and redirects, and keeps saturating fetch and stall counters.
module instruction_fetch #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] NOP_INSTR    = 32'h0000_0013
) (
    input logic                 clk,
    input logic                 rst_n,
    instruction_fetch_if.master bus
);
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic do_redirect;
    logic do_fetch;
    logic do_stall_count;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] if_id_pc_q;
    logic [WIDTH-1:0] if_id_instr_q;
    logic             if_id_valid_q;
    logic [31:0]      fetch_count_q;
    logic [31:0]      stall_count_q;

    // Redirect targets are forced word-aligned, so the low two bits are dropped on purpose.
    logic [1:0] unused_target_lsbs;
    assign unused_target_lsbs = bus.branch_target[1:0];

    // NOTE: reset is sampled on the clock edge only. It is synchronous, so rst_n is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // BOOT lasts exactly one cycle. RUN is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // NOTE: every always_comb output gets a default first. This keeps the decode free of latches.
    always_comb begin
        do_redirect    = 1'b0;
        do_fetch       = 1'b0;
        do_stall_count = 1'b0;
        if (state_q == RUN) begin
            do_redirect    = bus.branch_taken;
            do_fetch       = !bus.branch_taken && !bus.stall;
            do_stall_count = bus.stall;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments. Every register then samples its pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_VECTOR;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (do_redirect) begin
                pc_q          <= {bus.branch_target[WIDTH-1:2], 2'b00};
                if_id_pc_q    <= pc_q;
                if_id_instr_q <= NOP_INSTR;
                if_id_valid_q <= 1'b0;
            end else if (do_fetch) begin
                pc_q          <= pc_q + WIDTH'(4);
                if_id_pc_q    <= pc_q;
                if_id_instr_q <= bus.instruction;
                if_id_valid_q <= 1'b1;
                if (fetch_count_q != 32'hFFFF_FFFF) begin
                    fetch_count_q <= fetch_count_q + 32'd1;
                end
            end
            // A stall is counted even when a redirect overrides it.
            if (do_stall_count && stall_count_q != 32'hFFFF_FFFF) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign bus.pc_address  = pc_q;
    assign bus.if_id_pc    = if_id_pc_q;
    assign bus.if_id_instr = if_id_instr_q;
    assign bus.if_id_valid = if_id_valid_q;
    assign bus.fetch_count = fetch_count_q;
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. A small ROM model returns 32'h1000_0000 + word index
// for the first 64 words and NOP_INSTR everywhere else.
module tb_instruction_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    instruction_fetch_if #(.WIDTH(32)) bus ();

    instruction_fetch #(
        .WIDTH       (32),
        .RESET_VECTOR(32'h0000_0000),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (bus.pc_address < 32'h0000_0100) begin
            bus.instruction = 32'h1000_0000 + (bus.pc_address >> 2);
        end else begin
            bus.instruction = NOP;
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic valid);
        check({tag, ".if_id_pc"}, bus.if_id_pc, pc);
        check({tag, ".if_id_instr"}, bus.if_id_instr, instr);
        check({tag, ".if_id_valid"}, {31'd0, bus.if_id_valid}, {31'd0, valid});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        step();
        step();
        check("rst.pc", bus.pc_address, 32'h0);
        check_ifid("rst", 32'h0, NOP, 1'b0);
        check("rst.fetch_count", bus.fetch_count, 32'd0);
        check("rst.stall_count", bus.stall_count, 32'd0);

        // Free run: the BOOT edge, then fetches.
        rst_n = 1'b1;
        step();
        check("boot.pc", bus.pc_address, 32'h0);
        check_ifid("boot", 32'h0, NOP, 1'b0);
        check("boot.fetch_count", bus.fetch_count, 32'd0);
        step();
        check("run1.pc", bus.pc_address, 32'h4);
        check_ifid("run1", 32'h0, 32'h1000_0000, 1'b1);
        check("run1.fetch_count", bus.fetch_count, 32'd1);
        step();
        check("run2.pc", bus.pc_address, 32'h8);
        check_ifid("run2", 32'h4, 32'h1000_0001, 1'b1);
        check("run2.fetch_count", bus.fetch_count, 32'd2);

        // Stall for three cycles at PC 8.
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.pc", bus.pc_address, 32'h8);
            check_ifid("stall", 32'h4, 32'h1000_0001, 1'b1);
        end
        check("stall.stall_count", bus.stall_count, 32'd3);
        check("stall.fetch_count", bus.fetch_count, 32'd2);
        bus.stall = 1'b0;
        step();
        check("unstall.pc", bus.pc_address, 32'hC);
        check_ifid("unstall", 32'h8, 32'h1000_0002, 1'b1);

        // A redirect overrides the stall, and the target is aligned down.
        bus.stall = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_0022;
        step();
        check("br.pc", bus.pc_address, 32'h20);
        check_ifid("br", 32'hC, NOP, 1'b0);
        check("br.stall_count", bus.stall_count, 32'd4);
        check("br.fetch_count", bus.fetch_count, 32'd3);
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        step();
        check("br_tgt.pc", bus.pc_address, 32'h24);
        check_ifid("br_tgt", 32'h20, 32'h1000_0008, 1'b1);
        check("br_tgt.fetch_count", bus.fetch_count, 32'd4);

        // PC wrap through the top of the address space.
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        step();
        check("wrap0.pc", bus.pc_address, 32'hFFFF_FFFC);
        bus.branch_taken = 1'b0;
        step();
        check("wrap1.pc", bus.pc_address, 32'h0);
        check_ifid("wrap1", 32'hFFFF_FFFC, NOP, 1'b1);
        step();
        check("wrap2.pc", bus.pc_address, 32'h4);
        check_ifid("wrap2", 32'h0, 32'h1000_0000, 1'b1);

        // Reach PC 0x14 with a valid IF/ID, then reset with every other input active.
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_0010;
        step();
        bus.branch_taken = 1'b0;
        step();
        check("pre_rst.pc", bus.pc_address, 32'h14);
        check_ifid("pre_rst", 32'h10, 32'h1000_0004, 1'b1);
        check("pre_rst.fetch_count", bus.fetch_count, 32'd7);
        rst_n = 1'b0;
        bus.stall = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_0040;
        step();
        check("mid_rst.pc", bus.pc_address, 32'h0);
        check_ifid("mid_rst", 32'h0, NOP, 1'b0);
        check("mid_rst.fetch_count", bus.fetch_count, 32'd0);
        check("mid_rst.stall_count", bus.stall_count, 32'd0);
        rst_n = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        step();
        check("reboot.pc", bus.pc_address, 32'h0);
        check_ifid("reboot", 32'h0, NOP, 1'b0);
        step();
        check("refetch.pc", bus.pc_address, 32'h4);
        check_ifid("refetch", 32'h0, 32'h1000_0000, 1'b1);
        check("refetch.fetch_count", bus.fetch_count, 32'd1);

        // Fetch counter saturation.
        force dut.fetch_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_count_q;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sat.fetch_count", bus.fetch_count, 32'hFFFF_FFFF);
        end
        check("sat.pc", bus.pc_address, 32'h10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
